// File: rtl/bitty_fetch_if.sv
// Bus bundle between the bitty fetch unit and its surroundings: instruction
// memory on one side, the core control unit on the other.
//
// Handshake rules:
//   Memory side:
//   - mem_req is a level request.
//   - Once raised, it stays high with a stable mem_addr until either:
//     - a cycle with mem_ack=1, where mem_rdata is consumed in that same cycle, or
//     - the fetch unit gives up (fault).
//   - mem_ack has no meaning while mem_req=0.
//   Core side:
//   - run=1 means instruction is valid and held stable.
//   - The core answers with a single-cycle done. It may send branch_taken and
//     branch_target in that same cycle.
//   - done has no meaning while run=0.
//
// Signals:
//   mem_req/mem_addr          fetch request and address (fetch unit -> memory)
//   mem_ack/mem_rdata         acknowledge with read data (memory -> fetch unit)
//   instruction/run           current word and its valid flag (fetch unit -> core)
//   done/branch_taken/target  completion and next-pc selection (core -> fetch unit)
//   pc/halted/fault/retired   status outputs
//   dbg_state                 raw FSM state for observation
interface bitty_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instruction;
  logic              run;
  logic              done;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fault;
  logic [15:0]       retired;
  logic [2:0]        dbg_state;

  modport master (
    output mem_req, mem_addr, instruction, run, pc, halted, fault, retired, dbg_state,
    input  mem_ack, mem_rdata, done, branch_taken, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, instruction, run, pc, halted, fault, retired, dbg_state,
    output mem_ack, mem_rdata, done, branch_taken, branch_target
  );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch stage for the bitty core.
//
// Function:
//   - Owns the program counter.
//   - Fetches one word per instruction from instruction memory.
//   - Holds the word on instruction with run=1 until the core reports done.
//   - Then advances pc to pc+1, or to branch_target when the branch is taken.
//   - Stops for good in two cases, and only reset leaves either:
//     - a fetched HALT_WORD raises halted;
//     - a request left unacknowledged for TIMEOUT cycles raises fault.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; overrides everything
//   bus    bitty_fetch_if master modport (memory, core and status signals)
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module bitty_fetch_unit #(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 16,
  parameter int              TIMEOUT   = 15,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
) (
  input  logic            clk,
  input  logic            reset,
  bitty_fetch_if.master   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic [15:0]       r_retired;
  logic [CNT_W-1:0]  r_cnt;

  logic w_last_wait;
  logic w_is_halt;

  // True in the last cycle a request may go without an ack before it faults.
  assign w_last_wait = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_is_halt   = (bus.mem_rdata == HALT_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_retired <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus.mem_ack) begin
            r_instr <= bus.mem_rdata;
            r_cnt   <= '0;
            r_state <= w_is_halt ? S_HALT : S_EXEC;
          end else if (w_last_wait) begin
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (bus.done) begin
            if (r_retired != 16'hFFFF) begin
              r_retired <= r_retired + 16'd1;
            end
            // Plain addition wraps the top address back to 0.
            r_pc    <= bus.branch_taken ? bus.branch_target : (r_pc + ADDR_W'(1));
            r_state <= S_FETCH;
          end
        end
        S_HALT: r_state <= S_HALT;
        S_ERR:  r_state <= S_ERR;
        // An illegal encoding can only come from corruption; park in ERR.
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign bus.mem_req     = (r_state == S_FETCH);
  assign bus.mem_addr    = r_pc;
  assign bus.run         = (r_state == S_EXEC);
  assign bus.instruction = r_instr;
  assign bus.pc          = r_pc;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.fault       = (r_state == S_ERR);
  assign bus.retired     = r_retired;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit.
//
// Reference model:
//   - A behavioural machine tracks the state the core should see:
//     request pending, executing, halted, faulted, pc and retired count.
//   - It is advanced from the same stimulus that is driven into the DUT.
//
// Structure:
//   - Each step():
//     - drives inputs just after a falling edge;
//     - advances the model across the next rising edge;
//     - compares every output at the following falling edge.
//   - Directed sections add literal expectations.
//   - The run ends with randomized epochs.
module tb_bitty_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;
  localparam logic [DW-1:0] HW = 16'hFFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bitty_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  bitty_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .HALT_WORD(HW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [256];

  // Reference model
  logic          m_idle, m_req, m_run, m_halted, m_fault;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_instr;
  logic [15:0]   m_retired;
  int            m_wait;
  int            cur_delay;

  // Stimulus modes
  int            delay_mode = 0;   // -1 random, otherwise fixed ack delay
  int            done_mode  = 1;   // 0 random, 1 done every cycle
  int            br_mode    = 2;   // 0 random, 1 force taken, 2 force not taken
  logic [AW-1:0] br_tgt     = '0;
  logic          rst_next   = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_req = 1'b0; m_run = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    m_pc = '0; m_instr = '0; m_retired = '0; m_wait = 0; cur_delay = 0;
  endtask

  function automatic int pick_delay();
    int r;
    if (delay_mode >= 0) return delay_mode;
    r = $urandom_range(0, 99);
    if (r < 85) return $urandom_range(0, 3);
    if (r < 93) return TO - 1;
    return TO + 2;
  endfunction

  task automatic compare_all();
    chk("mem_req", bus.mem_req, m_req);
    chk("run", bus.run, m_run);
    chk("halted", bus.halted, m_halted);
    chk("fault", bus.fault, m_fault);
    chk("pc", bus.pc, m_pc);
    chk("retired", bus.retired, m_retired);
    chk("instruction", bus.instruction, m_instr);
    if (m_req) chk("mem_addr", bus.mem_addr, m_pc);
  endtask

  task automatic step();
    logic          ack, dn, bt;
    logic [DW-1:0] rd;
    logic [AW-1:0] tg;
    if (m_req) ack = (m_wait == cur_delay);
    else       ack = ($urandom_range(0, 3) == 0);
    rd = (ack && m_req) ? mem[m_pc] : DW'($urandom);
    dn = (done_mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
    bt = (br_mode == 1) ? 1'b1 : (br_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    tg = (br_mode == 1) ? br_tgt : AW'($urandom);
    reset             = rst_next;
    bus.mem_ack       = ack;
    bus.mem_rdata     = rd;
    bus.done          = dn;
    bus.branch_taken  = bt;
    bus.branch_target = tg;
    if (rst_next) begin
      model_reset();
    end else if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1; m_wait = 0; cur_delay = pick_delay();
    end else if (m_req) begin
      if (ack) begin
        m_instr = rd; m_req = 1'b0; m_wait = 0;
        if (rd == HW) m_halted = 1'b1;
        else          m_run = 1'b1;
      end else if (m_wait == TO - 1) begin
        m_req = 1'b0; m_fault = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (m_run && dn) begin
      m_run = 1'b0; m_req = 1'b1;
      if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
      m_pc = bt ? tg : (m_pc + 8'd1);
      m_wait = 0; cur_delay = pick_delay();
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
  endtask

  // kind 0: executing at pc a; 1: requesting address a; 2: executing with retired==a
  task automatic wait_cond(input int kind, input logic [AW-1:0] a);
    int  n;
    bit  hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 600) begin
      case (kind)
        0: hit = (bus.run === 1'b1) && (bus.pc === a);
        1: hit = (bus.mem_req === 1'b1) && (bus.mem_addr === a);
        default: hit = (bus.run === 1'b1) && (bus.retired === {8'h00, a});
      endcase
      if (!hit) begin
        step();
        n++;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_cond kind=%0d target=%0h not reached within %0d cycles", kind, a, n);
    end
  endtask

  task automatic fill_mem(input int halt_pct);
    logic [DW-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      if (v == HW) v = 16'h0000;
      if ($urandom_range(0, 99) < halt_pct) v = HW;
      mem[i] = v;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.done = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    fill_mem(0);
    mem[0] = 16'h1234; mem[1] = 16'h0101; mem[2] = 16'h0202;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    compare_all();

    // Reset release, first fetch and first execute
    delay_mode = 0; done_mode = 1; br_mode = 2;
    do_reset();
    chk("lit_idle_no_req", bus.mem_req, 1'b0);
    chk("lit_reset_retired", bus.retired, 16'd0);
    step();
    chk("lit_first_req", bus.mem_req, 1'b1);
    chk("lit_first_addr", bus.mem_addr, 8'h00);
    step();
    chk("lit_first_run", bus.run, 1'b1);
    chk("lit_first_instr", bus.instruction, 16'h1234);

    // Sequential run of three words
    wait_cond(1, 8'd3);
    chk("lit_seq_retired", bus.retired, 16'd3);
    chk("lit_seq_pc", bus.pc, 8'd3);

    // Taken branch at pc 5
    wait_cond(0, 8'd5);
    br_mode = 1; br_tgt = 8'h40;
    step();
    chk("lit_branch_addr", bus.mem_addr, 8'h40);
    chk("lit_branch_retired", bus.retired, 16'd6);

    // Wrap from 0xFF to 0x00
    br_tgt = 8'hFF;
    wait_cond(0, 8'h40);
    step();
    chk("lit_at_ff", bus.mem_addr, 8'hFF);
    br_mode = 2;
    wait_cond(0, 8'hFF);
    step();
    chk("lit_wrap_req", bus.mem_req, 1'b1);
    chk("lit_wrap_addr", bus.mem_addr, 8'h00);

    // Halt word at address 0
    mem[0] = HW;
    do_reset();
    step();
    step();
    chk("lit_halted", bus.halted, 1'b1);
    chk("lit_halt_instr", bus.instruction, 16'hFFFF);
    repeat (10) step();
    chk("lit_halt_no_run", bus.run, 1'b0);
    chk("lit_halt_no_req", bus.mem_req, 1'b0);
    mem[0] = 16'h1234;

    // Timeout: ack never arrives for the fetch at address 3
    do_reset();
    wait_cond(0, 8'd2);
    delay_mode = TO + 5;
    step();
    repeat (TO - 1) step();
    chk("lit_to_no_fault_yet", bus.fault, 1'b0);
    chk("lit_to_still_req", bus.mem_req, 1'b1);
    step();
    chk("lit_to_fault", bus.fault, 1'b1);
    chk("lit_to_pc", bus.pc, 8'd3);
    chk("lit_to_req_drop", bus.mem_req, 1'b0);

    // Ack in the last allowed cycle: normal capture
    delay_mode = 0;
    do_reset();
    wait_cond(0, 8'd2);
    delay_mode = TO - 1;
    step();
    repeat (TO) step();
    chk("lit_late_no_fault", bus.fault, 1'b0);
    chk("lit_late_run", bus.run, 1'b1);
    chk("lit_late_instr", bus.instruction, {16'h0000, mem[3]});

    // Reset while executing with retired == 7
    delay_mode = 0;
    do_reset();
    wait_cond(2, 8'd7);
    rst_next = 1'b1;
    step();
    chk("lit_rst_run", bus.run, 1'b0);
    chk("lit_rst_pc", bus.pc, 8'd0);
    chk("lit_rst_retired", bus.retired, 16'd0);
    rst_next = 1'b0;
    step();
    chk("lit_refetch_req", bus.mem_req, 1'b1);
    chk("lit_refetch_addr", bus.mem_addr, 8'h00);

    // Randomized epochs
    delay_mode = -1; done_mode = 0; br_mode = 0;
    for (int e = 0; e < 8; e++) begin
      fill_mem(1);
      do_reset();
      for (int c = 0; c < 500; c++) begin
        rst_next = ($urandom_range(0, 199) == 0);
        step();
      end
      rst_next = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
